// File: rtl/mseq_enc.sv
// mseq_enc: spreads serial data bits with a 31-chip M-sequence, LSB first.
// Define MSEQ_ENC_IDLE_SEQ_EN to send the bare template while idle.
module mseq_enc #(
  parameter logic [30:0] TEMPLATE = 31'b0011001001111101110001010110100,
  parameter int unsigned CHIP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic signal,
  output logic sym_start,
  output logic busy
);

  localparam int unsigned DW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CHIP_DIV - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state;
  logic cur_bit;
  logic [4:0] chip_idx;
  logic [DW-1:0] div_cnt;

  logic div_wrap;
  logic last_clk;
  logic active;
  logic xfer;

  assign div_wrap = (div_cnt == DIV_MAX);
  assign last_clk = div_wrap && (chip_idx == 5'd30);
  assign xfer = in_valid && in_ready;

`ifdef MSEQ_ENC_IDLE_SEQ_EN
  logic run;
  // Counters free-run in both states, so bits only land on period edges.
  assign active = run;
  assign in_ready = run && last_clk;
`else
  assign active = (state == SEND);
  assign in_ready = (state == IDLE) || (active && last_clk);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_bit <= 1'b0;
      chip_idx <= 5'd0;
      div_cnt <= '0;
      signal <= 1'b0;
      sym_start <= 1'b0;
      busy <= 1'b0;
`ifdef MSEQ_ENC_IDLE_SEQ_EN
      run <= 1'b0;
`endif
    end else begin
      sym_start <= 1'b0;
      if (xfer) begin
        state <= SEND;
        cur_bit <= in_bit;
        chip_idx <= 5'd0;
        div_cnt <= '0;
        signal <= TEMPLATE[0] ^ in_bit;
        sym_start <= 1'b1;
        busy <= 1'b1;
      end else if (active && last_clk) begin
        state <= IDLE;
        cur_bit <= 1'b0;
        chip_idx <= 5'd0;
        div_cnt <= '0;
        busy <= 1'b0;
`ifdef MSEQ_ENC_IDLE_SEQ_EN
        signal <= TEMPLATE[0];
        sym_start <= 1'b1;
`else
        signal <= 1'b0;
`endif
      end else if (active) begin
        if (div_wrap) begin
          chip_idx <= chip_idx + 5'd1;
          div_cnt <= '0;
          signal <= TEMPLATE[chip_idx + 5'd1] ^ cur_bit;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
`ifdef MSEQ_ENC_IDLE_SEQ_EN
      else begin
        run <= 1'b1;
        cur_bit <= 1'b0;
        chip_idx <= 5'd0;
        div_cnt <= '0;
        signal <= TEMPLATE[0];
        sym_start <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/mseq_enc.md
Name: mseq_enc

Overview:
- Transmit-side counterpart of the `dec` correlator: spreads a serial stream of data bits with the 31-chip M-sequence and emits a single-bit chip stream on `signal`.
- Each accepted data bit produces one symbol of 31 chips. Chip k of the symbol equals TEMPLATE[k] XOR bit, sent LSB first.
- A 0 bit therefore sends TEMPLATE unchanged; a 1 bit sends its complement.
- Sits upstream of `dec` (directly, or via the channel model). `signal` connects directly to `dec.signal`.

Parameters:
- TEMPLATE, 31'b0011001001111101110001010110100, spreading code; bit 0 is transmitted first.
- CHIP_DIV, 1, clock cycles per chip; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data bit on in_bit is offered.
- in_ready  output  1  encoder can accept a bit this cycle.
- in_bit  input  1  data bit to spread.
- signal  output  1  chip stream, registered.
- sym_start  output  1  one-cycle pulse on the first clock of chip 0 of every symbol.
- busy  output  1  high while a symbol is being transmitted.

Behaviour:
- Reset values (applied asynchronously while rst_n=0):
  - signal=0, sym_start=0, busy=0, in_ready=1.
  - chip counter = 0, divider counter = 0, state = IDLE.
- Registers:
  - state (IDLE, SEND).
  - cur_bit (1 bit).
  - chip_idx (5 bits, 0..30).
  - div_cnt, width $clog2(CHIP_DIV) with minimum 1.
- Handshake:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_bit is sampled only on that edge.
  - in_valid may stay high indefinitely; there is no transfer while in_ready=0.
- Latency: a transfer at edge N gives signal = TEMPLATE[0]^in_bit and sym_start=1 from edge N onward. Both are visible in cycle N+1.
- IDLE state:
  - in_ready=1, signal=0, busy=0.
  - On transfer: go to SEND, chip_idx=0, div_cnt=0, latch cur_bit.
- SEND state:
  - busy=1.
  - signal holds TEMPLATE[chip_idx]^cur_bit for CHIP_DIV cycles.
  - div_cnt counts 0..CHIP_DIV-1. At wrap, chip_idx increments.
- in_ready during SEND:
  - Asserted combinationally only in the final clock of the symbol (chip_idx=30, div_cnt=CHIP_DIV-1).
  - 0 in all other SEND cycles.
- End of symbol (final clock):
  - If a transfer occurs, start the next symbol immediately: chip_idx=0, new cur_bit, sym_start pulse. Output is gapless; symbol period = 31*CHIP_DIV cycles.
  - Otherwise return to IDLE; signal=0 from the next cycle.
- sym_start is high only on the first clock of chip 0. It is never asserted for CHIP_DIV-1 further cycles.
- Width rules:
  - chip_idx wraps 30 -> 0, never reaching 31.
  - div_cnt comparison is against CHIP_DIV-1 and is sized so CHIP_DIV=1 never overflows.
- Reset mid-symbol: the symbol is aborted immediately. No partial symbol resumes after rst_n deasserts. Outputs return to reset values.
- Mid-symbol protection: in_bit changes while in_ready=0 are ignored; cur_bit is stable for the whole symbol.

Optional Feature:
- Macro: MSEQ_ENC_IDLE_SEQ_EN.
- When defined:
  - IDLE transmits the unmodulated TEMPLATE continuously (cur_bit forced 0), with sym_start pulsing every 31*CHIP_DIV cycles. This lets the receiver keep correlation lock.
  - busy stays 0 during idle sequences.
  - in_ready is asserted only in the last clock of each period, in both IDLE and SEND. Data symbols are therefore always aligned to the free-running period.
  - After reset, the first idle period starts the cycle after rst_n deasserts.
- When undefined: IDLE drives signal=0, and bits are accepted on any IDLE cycle (as above).

Test Plan:
- Single 0 bit, CHIP_DIV=1:
  - signal over 31 cycles equals TEMPLATE LSB first; the first 8 chips are 0,0,1,0,1,1,0,1.
  - Exactly 16 ones are sent.
  - sym_start=1 only in cycle 1; busy low again at cycle 32.
- Single 1 bit, CHIP_DIV=1: chips are the complement of TEMPLATE; the first 8 chips are 1,1,0,1,0,0,1,0.
- Back-to-back bits 0,1,0 with in_valid held high:
  - sym_start at cycles 1, 32 and 63; no gap chip between symbols.
  - in_ready high only in cycles 31, 62 and 93 (plus IDLE).
- CHIP_DIV=3, bit 0: each chip held 3 cycles, symbol is 93 cycles, sym_start lasts 1 cycle.
- Reset asserted at chip 10 of a symbol:
  - signal, busy and sym_start go 0 immediately; in_ready=1.
  - A new bit after release starts again at chip 0.
- Loopback into `dec` with continuous 0 bits: `dec.data`=62 and `dec.buff_wr`=TEMPLATE once every 31 cycles. With MSEQ_ENC_IDLE_SEQ_EN defined, the same result holds with in_valid=0.
